// File: rtl/dff_pipe_chain_pkg.sv
// dff_pipe_chain_pkg: shared sizing helper for the pipe chain
package dff_pipe_chain_pkg;
    function automatic int cnt_w(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/dff_pipe_chain_if.sv
// dff_pipe_chain_if: valid/ready/data stream bundle
interface dff_pipe_chain_if #(parameter int WIDTH = 8);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/dff_pipe_chain_stage.sv
// dff_pipe_stage: one valid-tagged register slot of the chain
module dff_pipe_stage #(
    parameter int             WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             adv,
    input  logic             prev_v,
    input  logic [WIDTH-1:0] prev_d,
    output logic             v,
    output logic [WIDTH-1:0] d
);
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= 1'b0;
            d <= RESET_VAL;
        end else begin
            if (flush) v <= 1'b0;
            else if (adv) v <= prev_v;
            // data only moves with a real word, so bubbles never toggle it
            if (adv && prev_v && !flush) d <= prev_d;
        end
    end
endmodule

// File: rtl/dff_pipe_chain.sv
// dff_pipe_chain: back-pressurable fixed-latency register chain with bubble collapse
module dff_pipe_chain
    import dff_pipe_chain_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              CW        = cnt_w(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    dff_pipe_chain_if.slave        up,
    dff_pipe_chain_if.master       dn,
    output logic [CW-1:0]          occupancy
);
    logic [DEPTH:0]   w_v;
    logic [WIDTH-1:0] w_d [DEPTH+1];
    logic [DEPTH-1:0] w_adv;
    logic             w_in;
    logic             w_out;
    logic [CW-1:0]    r_occ;
    assign w_v[0] = up.valid;
    assign w_d[0] = up.data;
    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_stage
            // a stage advances when the output drains or any slot at or after it is empty
            assign w_adv[i] = dn.ready | ~(&w_v[DEPTH:i+1]);
            dff_pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
                .clk    (clk),
                .rst    (rst),
                .flush  (flush),
                .adv    (w_adv[i]),
                .prev_v (w_v[i]),
                .prev_d (w_d[i]),
                .v      (w_v[i+1]),
                .d      (w_d[i+1])
            );
        end
    endgenerate
    assign up.ready  = w_adv[0];
    assign dn.valid  = w_v[DEPTH];
    assign dn.data   = w_d[DEPTH];
    assign w_in      = up.valid & w_adv[0];
    assign w_out     = w_v[DEPTH] & dn.ready;
    assign occupancy = r_occ;
    always_ff @(posedge clk) begin
        if (rst || flush) r_occ <= '0;
        else r_occ <= r_occ + CW'(w_in) - CW'(w_out);
    end
endmodule

// File: tb/tb_dff_pipe_chain.sv
// tb_dff_pipe_chain: scoreboard bench for the pipe chain
module tb_dff_pipe_chain;
    localparam int DEPTH = 4;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [2:0] occupancy;
    dff_pipe_chain_if #(.WIDTH(8)) up_if ();
    dff_pipe_chain_if #(.WIDTH(8)) dn_if ();
    dff_pipe_chain #(.WIDTH(8), .DEPTH(DEPTH), .RESET_VAL(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .up        (up_if),
        .dn        (dn_if),
        .occupancy (occupancy)
    );
    always #5 clk = ~clk;
    logic [7:0] q  [$];
    int         qc [$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         n_out = 0;
    bit         lat_on = 1'b0;
    bit         last_acc;
    logic [7:0] last_out = 8'h00;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got %0h want %0h", tag, got, exp);
        else n_pass++;
    endtask
    task automatic step(input logic iv, input logic [7:0] id, input logic ordy,
                        input logic fl, input logic rs);
        logic [7:0] w;
        int         c;
        up_if.valid = iv;
        up_if.data  = id;
        dn_if.ready = ordy;
        flush       = fl;
        rst         = rs;
        #1;
        last_acc = iv && (up_if.ready === 1'b1) && !rs && !fl;
        if (!rs && dn_if.valid === 1'b1 && ordy) begin
            if (q.size() == 0) chk("spurious_out", 1, 0);
            else begin
                w = q.pop_front();
                c = qc.pop_front();
                n_out++;
                last_out = w;
                chk("order", {24'h0, dn_if.data}, {24'h0, w});
                if (lat_on) chk("latency", cyc - c, DEPTH - 1);
            end
        end
        if (rs || fl) begin
            q.delete();
            qc.delete();
        end else if (last_acc) begin
            q.push_back(id);
            qc.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("occupancy", {29'h0, occupancy}, q.size());
    endtask
    initial begin
        int sent;
        int base;
        // 1: reset with input activity
        step(1, 8'hAA, 0, 0, 1);
        step(1, 8'hAA, 0, 0, 1);
        chk("rst_out_valid", dn_if.valid, 0);
        chk("rst_out_data", dn_if.data, 8'h00);
        chk("rst_in_ready", up_if.ready, 1);
        // 2: back-to-back stream with latency tracking
        lat_on = 1'b1;
        base = n_out;
        for (int k = 0; k < 8; k++) step(1, 8'(k + 1), 1, 0, 0);
        chk("stream_occ", occupancy, 4);
        for (int k = 0; k < 6; k++) step(0, 8'h00, 1, 0, 0);
        chk("stream_count", n_out - base, 8);
        lat_on = 1'b0;
        // 3: back-pressure then drain
        sent = 0;
        for (int k = 0; k < 8; k++) begin
            step(1, 8'(8'h10 + sent), 0, 0, 0);
            if (last_acc) sent++;
        end
        chk("bp_accepted", sent, 4);
        chk("bp_in_ready", up_if.ready, 0);
        chk("bp_occ", occupancy, 4);
        base = n_out;
        for (int k = 0; k < 20 && (sent < 6 || q.size() != 0); k++) begin
            step(sent < 6, 8'(8'h10 + sent), 1, 0, 0);
            if (last_acc) sent++;
        end
        chk("bp_drained", n_out - base, 6);
        // 4: sparse input collapses into a full chain
        for (int k = 0; k < 12; k++) step(k % 3 == 0, 8'(8'h30 + k / 3), 0, 0, 0);
        chk("sparse_occ", occupancy, 4);
        chk("sparse_valid", dn_if.valid, 1);
        chk("sparse_head", dn_if.data, 8'h30);
        for (int k = 0; k < 6; k++) step(0, 8'h00, 1, 0, 0);
        chk("idle_valid", dn_if.valid, 0);
        chk("idle_data_hold", dn_if.data, last_out);
        // 5: flush a full chain with a word offered
        for (int k = 0; k < 4; k++) step(1, 8'(8'h20 + k), 0, 0, 0);
        chk("pre_flush_occ", occupancy, 4);
        step(1, 8'h99, 0, 1, 0);
        chk("flush_valid", dn_if.valid, 0);
        chk("flush_data_kept", dn_if.data, 8'h20);
        base = n_out;
        for (int k = 0; k < 6; k++) step(0, 8'h00, 1, 0, 0);
        chk("flush_no_out", n_out - base, 0);
        // 6: reset mid-stream, then first word sees full latency
        for (int k = 0; k < 3; k++) step(1, 8'(8'h40 + k), 0, 0, 0);
        chk("pre_rst_occ", occupancy, 3);
        step(1, 8'hAA, 0, 0, 1);
        chk("mid_rst_valid", dn_if.valid, 0);
        chk("mid_rst_data", dn_if.data, 8'h00);
        lat_on = 1'b1;
        base = n_out;
        step(1, 8'h50, 1, 0, 0);
        for (int k = 0; k < 6; k++) step(0, 8'h00, 1, 0, 0);
        chk("post_rst_count", n_out - base, 1);
        lat_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
